// File: rtl/event_debouncer_pkg.sv
// Shared types and helpers for the event debouncer FSM.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_QUAL_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_QUAL_LOW  = 2'd3
  } debounce_state_t;

  // Committed level implied by a state: qualifying-low still reports high.
  function automatic logic state_is_high(input debounce_state_t st);
    return (st == S_HIGH) || (st == S_QUAL_LOW);
  endfunction

  function automatic logic state_is_qual(input debounce_state_t st);
    return (st == S_QUAL_HIGH) || (st == S_QUAL_LOW);
  endfunction

endpackage

// File: rtl/event_debouncer_if.sv
// Raw event input, qualification enable and the conditioned level/edge outputs.
interface event_debouncer_if;

  logic i_raw;
  logic i_enable;
  logic o_level;
  logic o_rise;
  logic o_fall;
  logic o_busy;

  modport master (
    output i_raw,
    output i_enable,
    input  o_level,
    input  o_rise,
    input  o_fall,
    input  o_busy
  );

  modport slave (
    input  i_raw,
    input  i_enable,
    output o_level,
    output o_rise,
    output o_fall,
    output o_busy
  );

endinterface

// File: rtl/event_debouncer_sync_ff.sv
// Generic n-flop synchroniser with synchronous active-low reset.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = chain_q[STAGES-1];

endmodule

// File: rtl/event_debouncer.sv
// Synchronises and debounces one raw event input into a clean level plus rise/fall strobes.
module event_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  event_debouncer_if.slave   bus
);

  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit          ONE_SHOT  = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic s;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (bus.i_raw),
    .o_q     (s)
  );

  debounce_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   rise_d, fall_d;
  logic                   level_q, rise_q, fall_q, busy_q;

  // State register plus outputs registered from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= state_is_high(state_d);
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= state_is_qual(state_d);
    end
  end

  // Next-state: a candidate commits only after DEBOUNCE_CYCLES unbroken agreeing samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (bus.i_enable && s) begin
          if (ONE_SHOT) begin
            state_d = S_HIGH;
            rise_d  = 1'b1;
          end else begin
            state_d = S_QUAL_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_QUAL_HIGH: begin
        if (!bus.i_enable || !s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (bus.i_enable && !s) begin
          if (ONE_SHOT) begin
            state_d = S_LOW;
            fall_d  = 1'b1;
          end else begin
            state_d = S_QUAL_LOW;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_QUAL_LOW: begin
        if (!bus.i_enable || s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  assign bus.o_level = level_q;
  assign bus.o_rise  = rise_q;
  assign bus.o_fall  = fall_q;
  assign bus.o_busy  = busy_q;

endmodule
